// File: rtl/eth_pkg.sv
// Ethernet framing constants, sideband field positions, FSM encoding and keep helpers
// shared across the MAC TX chain.
package eth_pkg;

    localparam int ETH_HDR_BYTES = 14;
    localparam logic [15:0] ETHERTYPE_IPV4 = 16'h0800;
    localparam logic [15:0] ETHERTYPE_ARP  = 16'h0806;

    localparam int LEN_MSB  = 79;
    localparam int LEN_LSB  = 64;
    localparam int DMAC_MSB = 63;
    localparam int DMAC_LSB = 16;
    localparam int TYPE_MSB = 15;
    localparam int TYPE_LSB = 0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_HDR0,
        ST_HDR1,
        ST_PAYLOAD,
        ST_TAIL,
        ST_PAD
    } fsm_state_t;

    function automatic logic [3:0] keep_to_bytes(input logic [7:0] keep);
        logic [3:0] n;
        n = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n = n + {3'b000, keep[i]};
        end
        return n;
    endfunction

    function automatic logic [7:0] bytes_to_keep(input logic [3:0] n);
        logic [7:0] k;
        k = 8'h00;
        for (int i = 0; i < 8; i++) begin
            k[i] = (4'(i) < n);
        end
        return k;
    endfunction

endpackage

// File: rtl/mac_tx_framer_if.sv
// AXI-Stream bundle with a user sideband; master drives the beat, slave drives ready.
interface mac_tx_framer_if #(
    parameter int DATA_W = 64,
    parameter int USER_W = 80
);
    logic [DATA_W-1:0]   data;
    logic [USER_W-1:0]   user;
    logic [DATA_W/8-1:0] keep;
    logic                last;
    logic                valid;
    logic                ready;

    modport master (output data, user, keep, last, valid, input ready);
    modport slave  (input data, user, keep, last, valid, output ready);
endinterface

// File: rtl/axis_out_reg.sv
// Registered AXI-Stream output stage: loads a new beat (or a bubble) whenever the
// held beat is empty or being accepted, so data stays frozen under backpressure.
module axis_out_reg #(
    parameter int DATA_W = 64
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_push,
    input  logic [DATA_W-1:0]   i_data,
    input  logic [DATA_W/8-1:0] i_keep,
    input  logic                i_last,
    input  logic                i_ready,
    output logic                o_can_load,
    output logic                o_valid,
    output logic [DATA_W-1:0]   o_data,
    output logic [DATA_W/8-1:0] o_keep,
    output logic                o_last
);
    logic                r_valid;
    logic                r_last;
    logic [DATA_W-1:0]   r_data;
    logic [DATA_W/8-1:0] r_keep;
    logic                w_can_load;

    assign w_can_load = !r_valid || i_ready;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_valid <= 1'b0;
            r_last  <= 1'b0;
            r_data  <= '0;
            r_keep  <= '0;
        end else if (w_can_load) begin
            r_valid <= i_push;
            if (i_push) begin
                r_data <= i_data;
                r_keep <= i_keep;
                r_last <= i_last;
            end
        end
    end

    assign o_can_load = w_can_load;
    assign o_valid    = r_valid;
    assign o_data     = r_data;
    assign o_keep     = r_keep;
    assign o_last     = r_last;
endmodule

// File: rtl/mac_tx_framer.sv
// Prepends the 14-byte Ethernet header to a payload stream, shifting payload by 6 lanes,
// and zero-pads frames shorter than P_MIN_FRAME bytes (FCS is added downstream).
module mac_tx_framer #(
    parameter int P_MIN_FRAME = 60
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic [47:0]      i_src_mac,
    mac_tx_framer_if.slave   s_axis,
    mac_tx_framer_if.master  m_axis
);
    import eth_pkg::*;

    localparam logic [16:0] LP_MIN = 17'(P_MIN_FRAME);

    fsm_state_t  r_state;
    fsm_state_t  w_state_next;
    logic [79:0] r_user;
    logic [47:0] r_src;
    logic [47:0] r_rem;
    logic [2:0]  r_rem_n;
    logic [15:0] r_cnt;

    logic        w_can_load;
    logic        w_push;
    logic        w_s_ready;
    logic        w_data_end;
    logic        w_out_last;
    logic [3:0]  w_bytes;
    logic [3:0]  w_in_bytes;
    logic [63:0] w_raw;
    logic [63:0] w_out_data;
    logic [7:0]  w_out_keep;
    logic [47:0] w_dmac_le;
    logic [47:0] w_src_le;
    logic [16:0] w_total;
    logic [16:0] w_pad_left;
    logic [16:0] w_cnt_sum;
    logic        w_unused_len;

    // MACs arrive in network order (byte 0 in the MSBs); lane 0 goes first on the wire.
    generate
        for (genvar gi = 0; gi < 6; gi++) begin : g_mac_lanes
            assign w_dmac_le[8*gi +: 8] = r_user[DMAC_MSB - 8*gi -: 8];
            assign w_src_le[8*gi +: 8]  = r_src[47 - 8*gi -: 8];
        end
        for (genvar gi = 0; gi < 8; gi++) begin : g_lane_mask
            assign w_out_data[8*gi +: 8] = (w_bytes > 4'(gi)) ? w_raw[8*gi +: 8] : 8'h00;
        end
    endgenerate

    assign w_in_bytes   = keep_to_bytes(s_axis.keep);
    assign w_total      = {1'b0, r_cnt} + {13'd0, w_bytes};
    assign w_pad_left   = LP_MIN - {1'b0, r_cnt};
    assign w_cnt_sum    = {1'b0, r_cnt} + {13'd0, keep_to_bytes(w_out_keep)};
    assign w_unused_len = ^r_user[LEN_MSB:LEN_LSB];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: if (s_axis.valid) w_state_next = ST_HDR0;
            ST_HDR0: if (w_can_load) w_state_next = ST_HDR1;
            ST_HDR1, ST_PAYLOAD: begin
                if (s_axis.valid && w_can_load) begin
                    if (!s_axis.last)    w_state_next = ST_PAYLOAD;
                    else if (!w_data_end) w_state_next = ST_TAIL;
                    else                 w_state_next = w_out_last ? ST_IDLE : ST_PAD;
                end
            end
            ST_TAIL, ST_PAD: if (w_can_load) w_state_next = w_out_last ? ST_IDLE : ST_PAD;
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_push     = 1'b0;
        w_s_ready  = 1'b0;
        w_data_end = 1'b0;
        w_raw      = '0;
        w_bytes    = 4'd8;
        case (r_state)
            ST_HDR0: begin
                w_push = 1'b1;
                w_raw  = {w_src_le[15:0], w_dmac_le};
            end
            ST_HDR1, ST_PAYLOAD: begin
                w_push    = s_axis.valid;
                w_s_ready = w_can_load;
                w_raw     = {s_axis.data[15:0],
                             (r_state == ST_HDR1) ?
                                 {r_user[TYPE_LSB +: 8], r_user[TYPE_MSB -: 8], w_src_le[47:16]} :
                                 r_rem};
                if (s_axis.last && w_in_bytes <= 4'd2) begin
                    w_data_end = 1'b1;
                    w_bytes    = 4'd6 + w_in_bytes;
                end
            end
            ST_TAIL: begin
                w_push     = 1'b1;
                w_data_end = 1'b1;
                w_raw      = {16'h0000, r_rem};
                w_bytes    = {1'b0, r_rem_n};
            end
            ST_PAD: begin
                w_push     = 1'b1;
                w_data_end = 1'b1;
                w_bytes    = 4'd0;
            end
            default: ;
        endcase

        // Short frames keep emitting full zero-filled beats until the minimum is reachable.
        w_out_keep = bytes_to_keep(w_bytes);
        w_out_last = 1'b0;
        if (w_data_end) begin
            w_out_last = 1'b1;
            if (w_total < LP_MIN) begin
                if (w_pad_left > 17'd8) begin
                    w_out_keep = 8'hFF;
                    w_out_last = 1'b0;
                end else begin
                    w_out_keep = bytes_to_keep(w_pad_left[3:0]);
                end
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_user  <= '0;
            r_src   <= '0;
            r_rem   <= '0;
            r_rem_n <= '0;
            r_cnt   <= '0;
        end else begin
            if (r_state == ST_IDLE && s_axis.valid) begin
                r_user <= s_axis.user;
                r_src  <= i_src_mac;
                r_cnt  <= '0;
            end
            if (w_s_ready && s_axis.valid) begin
                r_rem   <= s_axis.data[63:16];
                r_rem_n <= (w_in_bytes > 4'd2) ? 3'(w_in_bytes - 4'd2) : 3'd0;
            end
            if (w_can_load && w_push) begin
                r_cnt <= w_cnt_sum[16] ? 16'hFFFF : w_cnt_sum[15:0];
            end
        end
    end

    axis_out_reg #(.DATA_W(64)) u_out_reg (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_push     (w_push),
        .i_data     (w_out_data),
        .i_keep     (w_out_keep),
        .i_last     (w_out_last),
        .i_ready    (m_axis.ready),
        .o_can_load (w_can_load),
        .o_valid    (m_axis.valid),
        .o_data     (m_axis.data),
        .o_keep     (m_axis.keep),
        .o_last     (m_axis.last)
    );

    assign s_axis.ready = w_s_ready;
    assign m_axis.user  = '0;
endmodule

// File: tb/tb_mac_tx_framer.sv
// Drives payload frames into mac_tx_framer and checks the framed output byte stream
// against a queue-based reference built from the Ethernet framing rules.
module tb_mac_tx_framer;
    import eth_pkg::*;

    localparam int P_MIN = 60;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
        logic [79:0] user;
        logic [47:0] src;
        logic        first;
    } in_beat_t;

    typedef struct packed {
        logic [63:0] data;
        logic [7:0]  keep;
        logic        last;
    } out_beat_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [47:0] src_mac;

    mac_tx_framer_if #(.DATA_W(64), .USER_W(80)) s_if ();
    mac_tx_framer_if #(.DATA_W(64), .USER_W(1))  m_if ();

    mac_tx_framer #(.P_MIN_FRAME(P_MIN)) dut (
        .i_clk     (clk),
        .i_rst     (rst),
        .i_src_mac (src_mac),
        .s_axis    (s_if),
        .m_axis    (m_if)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;
    int n_out_beats = 0;
    int n_out_bytes = 0;
    int n_frames = 0;
    in_beat_t  in_q[$];
    out_beat_t exp_q[$];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %h expected %h", tag, got, exp);
        end
    endtask

    // Reference: header + payload, zero-padded to P_MIN, cut into 8-byte beats.
    task automatic add_frame(input int len, input logic [47:0] dst, input logic [47:0] src,
                             input logic [15:0] etype);
        logic [7:0] pl[$];
        logic [7:0] fr[$];
        in_beat_t   ib;
        out_beat_t  ob;
        for (int i = 0; i < len; i++) pl.push_back(8'($urandom()));
        for (int b = 0; b * 8 < len; b++) begin
            ib.data  = {$urandom(), $urandom()};
            ib.keep  = 8'h00;
            for (int l = 0; l < 8; l++) begin
                if (b * 8 + l < len) begin
                    ib.data[8*l +: 8] = pl[b*8 + l];
                    ib.keep[l] = 1'b1;
                end
            end
            ib.last  = ((b + 1) * 8 >= len);
            ib.user  = {16'(len), dst, etype};
            ib.src   = src;
            ib.first = (b == 0);
            in_q.push_back(ib);
        end
        for (int i = 0; i < 6; i++) fr.push_back(dst[47 - 8*i -: 8]);
        for (int i = 0; i < 6; i++) fr.push_back(src[47 - 8*i -: 8]);
        fr.push_back(etype[15:8]);
        fr.push_back(etype[7:0]);
        foreach (pl[i]) fr.push_back(pl[i]);
        while (fr.size() < P_MIN) fr.push_back(8'h00);
        for (int b = 0; b * 8 < fr.size(); b++) begin
            ob.data = '0;
            ob.keep = 8'h00;
            for (int l = 0; l < 8; l++) begin
                if (b * 8 + l < fr.size()) begin
                    ob.data[8*l +: 8] = fr[b*8 + l];
                    ob.keep[l] = 1'b1;
                end
            end
            ob.last = ((b + 1) * 8 >= fr.size());
            exp_q.push_back(ob);
        end
    endtask

    // ready_mode: 0 always ready, 1 toggling, 2 random 70%.
    task automatic run(input int ready_mode, input int gap_pct, input int abort_after,
                       input int max_cycles);
        int        cyc = 0;
        int        consumed = 0;
        bit        stalled = 1'b0;
        bit        tog = 1'b1;
        bit        in_fire;
        bit        out_fire;
        out_beat_t sv;
        out_beat_t ex;
        n_out_beats = 0;
        n_out_bytes = 0;
        while ((in_q.size() != 0 || exp_q.size() != 0) && cyc < max_cycles) begin
            @(negedge clk);
            cyc++;
            case (ready_mode)
                0: m_if.ready = 1'b1;
                1: begin m_if.ready = tog; tog = !tog; end
                default: m_if.ready = ($urandom_range(0, 99) < 70);
            endcase
            src_mac = 48'({$urandom(), $urandom()});
            if (in_q.size() != 0 && $urandom_range(0, 99) >= gap_pct) begin
                s_if.valid = 1'b1;
                s_if.data  = in_q[0].data;
                s_if.keep  = in_q[0].keep;
                s_if.last  = in_q[0].last;
                s_if.user  = in_q[0].user;
                if (in_q[0].first) src_mac = in_q[0].src;
            end else begin
                s_if.valid = 1'b0;
            end
            #1;
            in_fire  = s_if.valid && s_if.ready;
            out_fire = m_if.valid && m_if.ready;
            if (stalled) begin
                chk("stall_valid", 64'(m_if.valid), 64'd1);
                chk("stall_data", m_if.data, sv.data);
                chk("stall_keep", 64'(m_if.keep), 64'(sv.keep));
                chk("stall_last", 64'(m_if.last), 64'(sv.last));
            end
            stalled = m_if.valid && !m_if.ready;
            sv.data = m_if.data;
            sv.keep = m_if.keep;
            sv.last = m_if.last;
            if (out_fire) begin
                n_out_beats++;
                n_out_bytes += $countones(m_if.keep);
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", 64'(m_if.valid), 64'd0);
                end else begin
                    ex = exp_q.pop_front();
                    chk("beat_data", m_if.data, ex.data);
                    chk("beat_keep", 64'(m_if.keep), 64'(ex.keep));
                    chk("beat_last", 64'(m_if.last), 64'(ex.last));
                    if (ex.last) begin
                        n_frames++;
                        $display("frame %0d out: %0d beats, %0d bytes so far in run",
                                 n_frames, n_out_beats, n_out_bytes);
                    end
                end
            end
            if (in_fire) begin
                void'(in_q.pop_front());
                consumed++;
                if (abort_after > 0 && consumed == abort_after) return;
            end
        end
        if (abort_after == 0) chk("drain_timeout", 64'(in_q.size() + exp_q.size()), 64'd0);
    endtask

    initial begin
        rst        = 1'b1;
        src_mac    = '0;
        s_if.valid = 1'b0;
        s_if.data  = '0;
        s_if.keep  = '0;
        s_if.last  = 1'b0;
        s_if.user  = '0;
        m_if.ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_m_valid", 64'(m_if.valid), 64'd0);
        chk("rst_m_last",  64'(m_if.last),  64'd0);
        chk("rst_m_data",  m_if.data,       64'd0);
        chk("rst_m_keep",  64'(m_if.keep),  64'd0);
        chk("rst_s_ready", 64'(s_if.ready), 64'd0);
        rst = 1'b0;

        add_frame(46, 48'h010203040506, 48'h0A0B0C0D0E0F, ETHERTYPE_IPV4);
        run(0, 0, 0, 500);
        chk("t46_beats", 64'(n_out_beats), 64'd8);
        chk("t46_bytes", 64'(n_out_bytes), 64'd60);

        add_frame(20, 48'h112233445566, 48'h0A0B0C0D0E0F, ETHERTYPE_ARP);
        run(0, 0, 0, 500);
        chk("t20_beats", 64'(n_out_beats), 64'd8);
        chk("t20_bytes", 64'(n_out_bytes), 64'd60);

        add_frame(64, 48'hFFFFFFFFFFFF, 48'h020000000001, ETHERTYPE_IPV4);
        run(0, 0, 0, 500);
        chk("t64_beats", 64'(n_out_beats), 64'd10);
        chk("t64_bytes", 64'(n_out_bytes), 64'd78);

        add_frame(1500, 48'h00AABBCCDDEE, 48'h001122334455, ETHERTYPE_IPV4);
        run(1, 0, 0, 2000);
        chk("t1500_bytes", 64'(n_out_bytes), 64'd1514);

        add_frame(46, 48'h0102030405A1, 48'h0A0B0C0D0EB1, ETHERTYPE_IPV4);
        add_frame(100, 48'h0102030405A2, 48'h0A0B0C0D0EB2, ETHERTYPE_ARP);
        run(0, 0, 0, 800);
        chk("b2b_beats", 64'(n_out_beats), 64'd23);

        add_frame(200, 48'h0C0C0C0C0C0C, 48'h0D0D0D0D0D0D, ETHERTYPE_IPV4);
        run(0, 0, 5, 500);
        @(posedge clk);
        #2;
        chk("pre_rst_valid", 64'(m_if.valid), 64'd1);
        rst = 1'b1;
        #1;
        chk("async_rst_valid", 64'(m_if.valid), 64'd0);
        chk("async_rst_ready", 64'(s_if.ready), 64'd0);
        s_if.valid = 1'b0;
        in_q.delete();
        exp_q.delete();
        @(negedge clk);
        rst = 1'b0;
        add_frame(30, 48'h0E0E0E0E0E0E, 48'h0F0F0F0F0F0F, ETHERTYPE_ARP);
        run(0, 0, 0, 500);
        chk("post_rst_beats", 64'(n_out_beats), 64'd8);

        for (int f = 0; f < 20; f++) begin
            add_frame($urandom_range(1, 300), 48'({$urandom(), $urandom()}),
                      48'({$urandom(), $urandom()}),
                      (f % 2 == 0) ? ETHERTYPE_ARP : 16'($urandom()));
        end
        run(2, 20, 0, 20000);

        repeat (2) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/mac_tx_framer.md
Name: mac_tx_framer

Overview:
- Sits directly downstream of the MAC-layer two-channel arbiter, between it and the 10G Ethernet MAC TX AXIS port.
- Takes one payload frame at a time, with the per-frame header info in the user sideband.
- Prepends the 14-byte Ethernet header (dst MAC, src MAC, EtherType), realigns the payload by 6 bytes, and zero-pads short frames to the minimum length. FCS is appended by the MAC core.

Parameters:
P_MIN_FRAME, 60, minimum output frame length in bytes (excl. FCS); 0 disables padding.

Ports:
i_clk  in  1  clock
i_rst  in  1  asynchronous, active-high reset
i_src_mac  in  48  local MAC, network order (byte0 = [47:40]); sampled at frame start
s_axis_data  in  64  payload; lane n = bits [8n+7:8n], lane 0 first on wire
s_axis_user  in  80  [79:64] payload byte length (informational), [63:16] dst MAC (byte0 = [63:56]), [15:0] EtherType
s_axis_keep  in  8  contiguous from lane 0; only non-FF on last beat
s_axis_last  in  1  last payload beat
s_axis_valid  in  1  input valid
s_axis_ready  out  1  input ready
m_axis_data  out  64  framed output, same lane order
m_axis_keep  out  8  contiguous from lane 0
m_axis_last  out  1  last frame beat
m_axis_valid  out  1  output valid
m_axis_ready  in  1  MAC TX ready; full backpressure honoured

Behaviour:
- Reset: m_axis_valid=0, m_axis_last=0, m_axis_data=0, m_axis_keep=0, s_axis_ready=0, FSM=IDLE, byte counter=0.
- Output is fully registered. An output register loads only when !m_axis_valid || m_axis_ready. data/keep/last stay stable while valid && !ready.
- Input beats are consumed only on s_axis_valid && s_axis_ready. s_axis_ready is asserted only in HDR1/PAYLOAD and only when the output register can load that cycle.
- Frame length is taken from s_axis_last/keep. user[79:64] is not used for sequencing.
- FSM states: IDLE, HDR0, HDR1, PAYLOAD, TAIL, PAD.
- IDLE:
  - On s_axis_valid (not consumed), latch user and i_src_mac, then go to HDR0.
  - First output beat is valid on the next cycle.
- HDR0: emit beat 0 = dst[0..5], src[0..1], keep FF. Go to HDR1 on load.
- HDR1:
  - Consume payload beat 0.
  - Emit beat 1 = src[2..5], type[hi], type[lo], p0[lane0..1].
  - Store lanes 2..7 in a 48-bit remainder register. Go to PAYLOAD.
- PAYLOAD:
  - Consume beat k; emit {in lanes 0..1 in out lanes 6..7, remainder in out lanes 0..5}.
  - Update the remainder with lanes 2..7.
- Last input beat with n valid bytes (n = popcount keep):
  - If n ≤ 2 (or n ≤ 2 in HDR1): the current beat ends the data. Unused lanes are driven to 0.
  - If n > 2: go to TAIL, which emits the n−2 remainder bytes (lanes above driven 0) with no input consumed.
- Byte counter: counts output bytes, 16-bit, saturating.
- Padding:
  - If the data-ending beat would bring the total below P_MIN_FRAME, that beat gets keep = FF, last = 0, then go to PAD.
  - PAD emits zero beats. The final pad beat has keep covering exactly up to P_MIN_FRAME and last = 1.
  - Otherwise the data-ending beat gets last = 1 and a keep of the true count.
- After the last beat is loaded, return to IDLE. Back-to-back frames therefore have at least one idle cycle at the input side and no output gap beyond the IDLE cycle.
- If s_axis_valid drops mid-frame, the framer stalls in its current state, output valid drops after the pending beat drains, and no bubble data is emitted.
- Reset mid-frame: all state is discarded immediately and the partial frame is lost. The downstream MAC sees valid fall without last, which is accepted.
- Payload of 0 bytes is illegal; behaviour is undefined.

Decomposition:
- Shared package eth_pkg holds:
  - ETH_HDR_BYTES = 14
  - ETHERTYPE_IPV4 = 16'h0800
  - ETHERTYPE_ARP = 16'h0806
  - user field bit positions (LEN_MSB/LSB, DMAC_MSB/LSB, TYPE_MSB/LSB)
  - the keep↔byte-count conversion functions
  - the FSM state encoding
- One natural sub-module: axis_out_reg (registered output stage with load enable), reusable across the TX chain.

Test Plan:
- 46-byte payload, dst 01_02_03_04_05_06, src 0A_0B_0C_0D_0E_0F, type 0800, m_ready = 1 → 8 beats. Beat 0 lanes = 01..06,0A,0B. Beat 1 = 0C..0F,08,00,p0,p1. Beat 7 keep = 0x0F, last = 1. Total 60 bytes.
- 20-byte payload → payload ends in beat 4 with a partial keep, which is forced to FF. Beat 5 is all-zero pad (FF), beat 7 is pad with keep 0x0F and last = 1. Total 60 bytes, pad bytes all 0.
- 64-byte payload, last keep = FF → TAIL beat with 6 bytes, keep 0x3F. Total 78 bytes, 10 beats, no pad.
- 1500-byte payload with m_ready toggling 1/0 every cycle → output bytes match the reference model exactly, with no duplicates or drops. Data stays stable while stalled.
- Two back-to-back frames (the second's valid held high) → the second frame's user and i_src_mac are captured independently. The second frame's beat 0 appears after the first frame's last is accepted.
- Assert i_rst during PAYLOAD → m_axis_valid goes to 0 asynchronously. The next frame after reset is framed correctly from beat 0.
